// File: rtl/bnn_conv_seq_if.sv
// Bus bundle for the time-multiplexed binary conv layer: start/done control,
// live layer operands, result map and an FSM state tap for checkers.
interface bnn_conv_seq_if #(
  parameter int IMG_IN_SIZE     = 30,
  parameter int KERNEL_SIZE     = 3,
  parameter int IN_CHANL        = 1,
  parameter int OUT_CHANL       = 8,
  parameter int THRESHOLD_WIDTH = 8,
  parameter int POOL            = 1
);
  localparam int CONV_SIZE = IMG_IN_SIZE - KERNEL_SIZE + 1;
  localparam int OUT_SIZE  = (POOL != 0) ? CONV_SIZE / 2 : CONV_SIZE;

  // Handshake: start is sampled only while idle (busy=0, done=0); one accepted
  // start clears the map, busy stays high while output bits are produced, then
  // done pulses high for exactly one cycle. Operands must hold from acceptance
  // until done; the map holds from done until the next accepted start.
  logic                                          start;
  logic [IN_CHANL*IMG_IN_SIZE*IMG_IN_SIZE-1:0]   in_image;
  logic [OUT_CHANL*IN_CHANL*KERNEL_SIZE*KERNEL_SIZE-1:0] weights;
  logic [OUT_CHANL*THRESHOLD_WIDTH-1:0]          threshold;
  logic                                          busy;
  logic                                          done;
  logic [OUT_CHANL*OUT_SIZE*OUT_SIZE-1:0]        out_feature_maps;
  logic [1:0]                                    dbg_state;

  modport master (
    output start, in_image, weights, threshold,
    input  busy, done, out_feature_maps, dbg_state
  );

  modport slave (
    input  start, in_image, weights, threshold,
    output busy, done, out_feature_maps, dbg_state
  );
endinterface

// File: rtl/bnn_conv_seq.sv
// Binary conv layer (XNOR-popcount, threshold, optional 2x2 OR-pool) that
// produces one output bit per clock, walking col fastest, then row, then oc.
module bnn_conv_seq #(
  parameter int IMG_IN_SIZE     = 30,
  parameter int KERNEL_SIZE     = 3,
  parameter int IN_CHANL        = 1,
  parameter int OUT_CHANL       = 8,
  parameter int THRESHOLD_WIDTH = 8,
  parameter int POOL            = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  bnn_conv_seq_if.slave bus
);
  localparam int CONV_SIZE = IMG_IN_SIZE - KERNEL_SIZE + 1;
  localparam int OUT_SIZE  = (POOL != 0) ? CONV_SIZE / 2 : CONV_SIZE;
  localparam int PS        = (POOL != 0) ? 2 : 1;
  localparam int N_WIN     = IN_CHANL * KERNEL_SIZE * KERNEL_SIZE;
  localparam int PC_W      = $clog2(N_WIN + 1);
  localparam int CMP_W     = (PC_W > THRESHOLD_WIDTH) ? PC_W : THRESHOLD_WIDTH;
  localparam int IMG_BITS  = IN_CHANL * IMG_IN_SIZE * IMG_IN_SIZE;
  localparam int W_BITS    = OUT_CHANL * N_WIN;
  localparam int OUT_BITS  = OUT_CHANL * OUT_SIZE * OUT_SIZE;
  localparam int IMG_IW    = $clog2(IMG_BITS);
  localparam int W_IW      = $clog2(W_BITS);
  localparam int OUT_IW    = $clog2(OUT_BITS);
  localparam int OC_W      = (OUT_CHANL > 1) ? $clog2(OUT_CHANL) : 1;
  localparam int RC_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                       r_state;
  logic                         r_busy;
  logic                         r_done;
  logic [OUT_BITS-1:0]          r_out;
  logic [OC_W-1:0]              r_oc;
  logic [RC_W-1:0]              r_row;
  logic [RC_W-1:0]              r_col;

  logic                         w_bit;
  logic                         w_match;
  logic [PC_W-1:0]              w_pc;
  logic [THRESHOLD_WIDTH-1:0]   w_thr;
  int                           w_img_idx;
  int                           w_w_idx;
  int                           w_out_idx;
  logic                         w_last_col;
  logic                         w_last_row;
  logic                         w_last_oc;

  assign w_last_col = (r_col == RC_W'(OUT_SIZE - 1));
  assign w_last_row = (r_row == RC_W'(OUT_SIZE - 1));
  assign w_last_oc  = (r_oc == OC_W'(OUT_CHANL - 1));

  // One pooled output bit: any of the PSxPS conv windows reaching threshold.
  always_comb begin
    w_bit     = 1'b0;
    w_match   = 1'b0;
    w_pc      = '0;
    w_thr     = '0;
    w_img_idx = 0;
    w_w_idx   = 0;
    w_out_idx = int'(r_oc) * OUT_SIZE * OUT_SIZE + int'(r_row) * OUT_SIZE + int'(r_col);
    for (int oc = 0; oc < OUT_CHANL; oc++) begin
      if (OC_W'(oc) == r_oc) w_thr = bus.threshold[oc*THRESHOLD_WIDTH +: THRESHOLD_WIDTH];
    end
    for (int dr = 0; dr < PS; dr++) begin
      for (int dc = 0; dc < PS; dc++) begin
        w_pc = '0;
        for (int ic = 0; ic < IN_CHANL; ic++) begin
          for (int kr = 0; kr < KERNEL_SIZE; kr++) begin
            for (int kc = 0; kc < KERNEL_SIZE; kc++) begin
              w_img_idx = ic * IMG_IN_SIZE * IMG_IN_SIZE
                        + (int'(r_row) * PS + dr + kr) * IMG_IN_SIZE
                        + int'(r_col) * PS + dc + kc;
              w_w_idx   = (int'(r_oc) * IN_CHANL + ic) * KERNEL_SIZE * KERNEL_SIZE
                        + kr * KERNEL_SIZE + kc;
              w_match   = bus.in_image[IMG_IW'(w_img_idx)] ~^ bus.weights[W_IW'(w_w_idx)];
              w_pc      = w_pc + PC_W'(w_match);
            end
          end
        end
        if (CMP_W'(w_pc) >= CMP_W'(w_thr)) w_bit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_oc    <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_out   <= '0;
            r_oc    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_out[OUT_IW'(w_out_idx)] <= w_bit;
          if (!w_last_col) begin
            r_col <= r_col + 1'b1;
          end else begin
            r_col <= '0;
            if (!w_last_row) begin
              r_row <= r_row + 1'b1;
            end else begin
              r_row <= '0;
              if (!w_last_oc) begin
                r_oc <= r_oc + 1'b1;
              end else begin
                r_oc    <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.out_feature_maps = r_out;
  assign bus.dbg_state        = r_state;
endmodule

// File: tb/tb_bnn_conv_seq.sv
// Bench for bnn_conv_seq: 6x6 image, 3x3 kernel, 2 output channels, one
// instance with 2x2 pooling and one without, checked against a reference model.
module tb_bnn_conv_seq;
  logic        clk;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic [35:0] img;
  logic [17:0] wts;
  logic [15:0] thr;
  int          total;
  int          bad;

  bnn_conv_seq_if #(.IMG_IN_SIZE(6), .KERNEL_SIZE(3), .IN_CHANL(1), .OUT_CHANL(2),
                    .THRESHOLD_WIDTH(8), .POOL(1)) bus_a ();
  bnn_conv_seq_if #(.IMG_IN_SIZE(6), .KERNEL_SIZE(3), .IN_CHANL(1), .OUT_CHANL(2),
                    .THRESHOLD_WIDTH(8), .POOL(0)) bus_b ();

  assign bus_a.start     = start_a;
  assign bus_a.in_image  = img;
  assign bus_a.weights   = wts;
  assign bus_a.threshold = thr;
  assign bus_b.start     = start_b;
  assign bus_b.in_image  = img;
  assign bus_b.weights   = wts;
  assign bus_b.threshold = thr;

  bnn_conv_seq #(.IMG_IN_SIZE(6), .KERNEL_SIZE(3), .IN_CHANL(1), .OUT_CHANL(2),
                 .THRESHOLD_WIDTH(8), .POOL(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  bnn_conv_seq #(.IMG_IN_SIZE(6), .KERNEL_SIZE(3), .IN_CHANL(1), .OUT_CHANL(2),
                 .THRESHOLD_WIDTH(8), .POOL(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: full 4x4 conv maps first, then optional OR-pool
  function automatic logic [31:0] ref_model(input logic [35:0] im, input logic [17:0] w,
                                            input logic [15:0] th, input bit pool);
    bit          cm[2][4][4];
    logic [31:0] r;
    int          pc;
    r = '0;
    for (int oc = 0; oc < 2; oc++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) begin
          pc = 0;
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              if (im[(y + ky) * 6 + x + kx] == w[oc * 9 + ky * 3 + kx]) pc++;
          cm[oc][y][x] = (pc >= int'(th[oc * 8 +: 8]));
        end
    for (int oc = 0; oc < 2; oc++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++)
          if (pool) begin
            if (y < 2 && x < 2)
              r[oc * 4 + y * 2 + x] = cm[oc][2*y][2*x] | cm[oc][2*y][2*x+1]
                                    | cm[oc][2*y+1][2*x] | cm[oc][2*y+1][2*x+1];
          end else begin
            r[oc * 16 + y * 4 + x] = cm[oc][y][x];
          end
    return r;
  endfunction

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver helpers
  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? bus_b.busy : bus_a.busy;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? bus_b.done : bus_a.done;
  endfunction

  function automatic logic [31:0] get_out(input bit sel);
    return sel ? bus_b.out_feature_maps : {24'h0, bus_a.out_feature_maps};
  endfunction

  // one layer evaluation; returns at the negedge after the done cycle (IDLE)
  task automatic run(input bit sel, input int n_pos, input int repulse_cyc,
                     input bit pulse_done, input bit no_wait, output logic [31:0] res);
    int cyc;
    int busy_cnt;
    int got;
    if (!no_wait) @(negedge clk);
    set_start(sel, 1'b1);
    cyc = 0;
    busy_cnt = 0;
    got = 0;
    while (got == 0 && cyc < n_pos + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        set_start(sel, 1'b0);
        check("cleared_at_start", get_out(sel), 32'h0);
      end
      if (repulse_cyc != 0 && cyc == repulse_cyc) set_start(sel, 1'b1);
      if (repulse_cyc != 0 && cyc == repulse_cyc + 1) set_start(sel, 1'b0);
      if (get_busy(sel)) busy_cnt++;
      if (get_done(sel)) got = cyc;
    end
    check("done_latency", got, n_pos + 1);
    check("busy_cycles", busy_cnt, n_pos);
    res = get_out(sel);
    if (pulse_done) set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    check("done_one_cycle", {31'h0, get_done(sel)}, 32'h0);
    check("idle_after_done", {31'h0, get_busy(sel)}, 32'h0);
    check("out_held", get_out(sel), res);
  endtask

  initial begin
    logic [31:0] res;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    img     = '0;
    wts     = '0;
    thr     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, bus_a.busy}, 32'h0);
    check("rst_done", {31'h0, bus_a.done}, 32'h0);
    check("rst_out", {24'h0, bus_a.out_feature_maps}, 32'h0);
    rst_n = 1'b1;

    // 1: all ones, threshold 9
    img = '1; wts = '1; thr = {8'd9, 8'd9};
    run(1'b0, 8, 0, 1'b0, 1'b0, res);
    check("t1_all_ones", res, 32'hFF);

    // 6 (back-to-back) then 2: threshold 10 started the cycle after done
    thr = {8'd10, 8'd10};
    run(1'b0, 8, 0, 1'b0, 1'b1, res);
    check("t2_thr10", res, 32'h00);

    // 3: ch0 weights 1, ch1 weights 0, threshold 1
    img = '1; wts = {9'h000, 9'h1FF}; thr = {8'd1, 8'd1};
    run(1'b0, 8, 0, 1'b0, 1'b0, res);
    check("t3_split", res, 32'h0F);

    // 4: no pooling, single hot pixel
    img = 36'h1; wts = '0; thr = {8'd9, 8'd9};
    run(1'b1, 32, 0, 1'b0, 1'b0, res);
    check("t4_nopool", res, 32'hFFFE_FFFE);

    // 5: start re-pulsed mid-CONV and in DONE
    img = '1; wts = '1; thr = {8'd9, 8'd9};
    run(1'b0, 8, 4, 1'b1, 1'b0, res);
    check("t5_repulse", res, 32'hFF);
    @(negedge clk);
    check("t5_no_restart", {31'h0, bus_a.busy}, 32'h0);

    // 5b: reset mid-operation
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_before_rst", {31'h0, bus_a.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {31'h0, bus_a.busy}, 32'h0);
    check("t5_rst_done", {31'h0, bus_a.done}, 32'h0);
    check("t5_rst_out", {24'h0, bus_a.out_feature_maps}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      repeat (15) begin
        @(negedge clk);
        if (bus_a.done || bus_a.busy) done_seen++;
      end
      check("t5_no_done_after_rst", done_seen, 0);
    end

    // randomized operands on both instances
    for (int it = 0; it < 6; it++) begin
      img = {$urandom, $urandom};
      wts = 18'($urandom);
      thr = {8'($urandom_range(0, 10)), 8'($urandom_range(0, 10))};
      run(1'b0, 8, 0, 1'b0, 1'b0, res);
      check("rand_pool", res, ref_model(img, wts, thr, 1'b1) & 32'hFF);
      run(1'b1, 32, 0, 1'b0, 1'b0, res);
      check("rand_nopool", res, ref_model(img, wts, thr, 1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
